// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped programmable down-counter with interrupt
module timer_counter #(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic        ctrl_en;
  logic [1:0]  ctrl_mode;
  logic        ctrl_im;
  logic [31:0] preset;
  logic [31:0] count, count_nx;
  logic        irq_pending, pending_nx;
  logic        clr_en;
  logic        set_pend;
  logic        clr_pend_fsm;
  logic        wr_ctrl;
  logic        wr_preset;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

  // Next-state and counter update; modes 2 and 3 fall back to one-shot behaviour.
  always_comb begin
    state_nx     = state;
    count_nx     = count;
    clr_en       = 1'b0;
    set_pend     = 1'b0;
    clr_pend_fsm = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_en) state_nx = LOAD;
      end
      LOAD: begin
        count_nx = preset;
        state_nx = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_nx = IDLE;
        end else if (count > 32'd1) begin
          count_nx = count - 32'd1;
        end else begin
          count_nx = 32'd0;
          set_pend = 1'b1;
          state_nx = INT;
        end
      end
      INT: begin
        if (ctrl_mode == 2'd1) begin
          clr_pend_fsm = 1'b1;
          state_nx     = LOAD;
        end else begin
          clr_en   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // A new expiry wins over a same-cycle acknowledge so no interrupt is lost.
  always_comb begin
    pending_nx = irq_pending;
    if (set_pend) begin
      pending_nx = 1'b1;
    end else if (wr_ctrl || wr_preset || clr_pend_fsm) begin
      pending_nx = 1'b0;
    end
  end

  // Register file and FSM state; a CPU write to CTRL overrides the one-shot EN clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ctrl_en     <= 1'b0;
      ctrl_mode   <= 2'd0;
      ctrl_im     <= 1'b0;
      preset      <= PRESET_RST;
      count       <= 32'd0;
      irq_pending <= 1'b0;
    end else begin
      state       <= state_nx;
      count       <= count_nx;
      irq_pending <= pending_nx;
      if (wr_ctrl) begin
        ctrl_en   <= din[0];
        ctrl_mode <= din[2:1];
        ctrl_im   <= din[3];
      end else if (clr_en) begin
        ctrl_en <= 1'b0;
      end
      if (wr_preset) preset <= din;
    end
  end

  // Side-effect-free read mux.
  always_comb begin
    dout = 32'h0;
    case (addr)
      ADDR_CTRL:   dout = {28'h0, ctrl_im, ctrl_mode, ctrl_en};
      ADDR_PRESET: dout = preset;
      ADDR_COUNT:  dout = count;
      default:     dout = 32'h0;
    endcase
  end

  assign irq = ctrl_im & irq_pending;

endmodule
